pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Upstream neighbour of the opcode control decoder. Holds the PC and fetches 16-bit instructions
//  from instruction memory over a req/ready handshake. Presents each instruction to decode for exactly one EXEC cycle.
//  Computes the next PC from the decoder's PCSource, halt and branch-condition inputs plus the Z/V/N flags.
// PARAMETERS
//  ADDR_W    16      PC / instruction-address width
//  RESET_PC  16'h0000  PC value loaded on reset
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  imem_req     out  1       fetch request; imem_addr valid while high
//  imem_addr    out  ADDR_W  fetch address (= PC)
//  imem_ready   in   1       imem_rdata valid this cycle; completes the fetch
//  imem_rdata   in   16      instruction word from memory
//  instr_out    out  16      latched instruction, to decoder/datapath
//  instr_valid  out  1       high for the single EXEC cycle of each instruction
//  pc_plus2     out  ADDR_W  PC+2 (PCS writeback, B base)
//  pc_source    in   2       from decoder: 00 seq, 01 BR (register), 11 B (PC-relative), 10 = seq
//  hlt          in   1       from decoder: halt instruction
//  cond         in   3       branch condition code (instr[11:9])
//  br_offset    in   9       signed word offset for B (instr[8:0])
//  br_target    in   ADDR_W  register value for BR
//  flag_z/flag_v/flag_n in 1 each  flags register outputs
//  halted       out  1       sticky halt indicator
// BEHAVIOUR
//  States: FETCH, EXEC, HALT. Reset (any state, any cycle): state<=FETCH, pc<=RESET_PC,
//   instr_out<=0; outstanding fetch abandoned; rst has priority over imem_ready/hlt.
//  Outputs: imem_req=(state==FETCH)&&!rst; instr_valid=(state==EXEC); halted=(state==HALT);
//   imem_addr=pc; pc_plus2=pc+2 (mod 2^ADDR_W). Reset values: imem_req 0, instr_valid 0,
//   halted 0, imem_addr RESET_PC.
//  FETCH: hold imem_addr stable; on imem_ready=1 latch imem_rdata into instr_out, go EXEC.
//   imem_ready=0 -> stay, unlimited wait states.
//  EXEC (exactly 1 cycle): pc_source/hlt/cond/offset/target/flags sampled this cycle.
//   hlt=1 -> HALT, pc unchanged (points at HLT instruction). Else pc<=next_pc, -> FETCH.
//  next_pc: 00/10 -> pc+2; 11 -> taken ? pc+2+(sext(br_offset)<<1) : pc+2;
//   01 -> taken ? {br_target[ADDR_W-1:1],1'b0} : pc+2. All sums wrap mod 2^ADDR_W.
//  taken by cond: 000 Z==0; 001 Z==1; 010 Z==0&&N==0; 011 N==1; 100 Z==1||(Z==0&&N==0);
//   101 N==1||Z==1; 110 V==1; 111 always.
//  HALT: sticky until rst; imem_req 0, instr_valid 0, imem_ready ignored.
//  Throughput: 2 cycles/instruction with zero-wait memory; instr_valid 1 cycle after ready.
//  PC bit 0 always 0.
// TESTING
//  1 rst 1 cycle, imem_ready=1 always, pc_source=00 -> imem_addr 0000,0002,0004 on successive
//    FETCH cycles; instr_valid pattern 0,1,0,1; instr_out = word supplied at each fetch.
//  2 imem_ready low 3 cycles at addr 0x0004 -> addr held, imem_req held 1, instr_valid 0;
//    ready on 4th cycle -> instr_valid=1 next cycle with that word.
//  3 PC=0x0010, pc_source=11, cond=001, br_offset=9'h1FE: Z=1 -> next addr 0x000E;
//    Z=0 -> 0x0012. cond=111 offset 9'h0FF -> 0x0210.
//  4 PC=0x0040, pc_source=01, cond=110, br_target=0x1235: V=1 -> 0x1234; V=0 -> 0x0042.
//  5 hlt=1 at PC=0x0020 -> halted=1 next cycle, imem_req 0 for 20 cycles, imem_addr 0x0020;
//    then rst -> halted 0, fetch resumes at 0x0000.
//  6 PC=0xFFFE seq -> 0x0000; rst during FETCH wait with imem_ready=1 same cycle -> no
//    instr_valid, imem_addr=RESET_PC after reset.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [15:0]       imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction fetcher: FETCH/EXEC/HALT sequencing, presents each
// instruction for one EXEC cycle and resolves the next PC from decoder controls and flags.
module pc_fetch_unit #(
  parameter int unsigned            ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_unit_if.master   imem,
  output logic [15:0]       instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_plus2,
  input  logic [1:0]        pc_source,
  input  logic              hlt,
  input  logic [2:0]        cond,
  input  logic [8:0]        br_offset,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              flag_z,
  input  logic              flag_v,
  input  logic              flag_n,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic              taken;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] rel_pc;
  logic [ADDR_W-1:0] reg_pc;
  logic [ADDR_W-1:0] next_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Branch condition evaluation against the flags register
  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = !flag_z;
      3'b001:  taken = flag_z;
      3'b010:  taken = !flag_z && !flag_n;
      3'b011:  taken = flag_n;
      3'b100:  taken = flag_z || (!flag_z && !flag_n);
      3'b101:  taken = flag_n || flag_z;
      3'b110:  taken = flag_v;
      default: taken = 1'b1;
    endcase
  end

  // Word offset is sign-extended and scaled to bytes; register targets are forced even
  assign seq_pc = pc_q + ADDR_W'(2);
  assign rel_pc = seq_pc + {{(ADDR_W-10){br_offset[8]}}, br_offset, 1'b0};
  assign reg_pc = br_target & ~ADDR_W'(1);

  always_comb begin
    next_pc = seq_pc;
    if (pc_source == 2'b11 && taken) next_pc = rel_pc;
    if (pc_source == 2'b01 && taken) next_pc = reg_pc;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          instr_d = imem.imem_rdata;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (hlt) begin
          state_d = HALT;
        end else begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH) && !rst;
  assign imem.imem_addr = pc_q;
  assign instr_out      = instr_q;
  assign instr_valid    = (state_q == EXEC);
  assign halted         = (state_q == HALT);
  assign pc_plus2       = seq_pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized
// instruction streams compared against a PC-level reference model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [15:0] pc_plus2;
  logic [1:0]  pc_source;
  logic        hlt;
  logic [2:0]  cond;
  logic [8:0]  br_offset;
  logic [15:0] br_target;
  logic        flag_z, flag_v, flag_n;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_unit_if #(.ADDR_W(16)) imem ();

  pc_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .pc_plus2    (pc_plus2),
    .pc_source   (pc_source),
    .hlt         (hlt),
    .cond        (cond),
    .br_offset   (br_offset),
    .br_target   (br_target),
    .flag_z      (flag_z),
    .flag_v      (flag_v),
    .flag_n      (flag_n),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: next fetch address from the architectural branch rules
  function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [1:0] src,
                                             input logic [2:0] c, input logic [8:0] off,
                                             input logic [15:0] tgt, input logic z, v, n);
    bit t;
    int s;
    logic [31:0] r;
    case (c)
      3'd0: t = !z;
      3'd1: t = z;
      3'd2: t = !z && !n;
      3'd3: t = n;
      3'd4: t = z || (!z && !n);
      3'd5: t = n || z;
      3'd6: t = v;
      default: t = 1'b1;
    endcase
    s = int'($signed(off));
    r = 32'(int'(pc) + 2);
    if (src == 2'b11 && t) r = 32'(int'(pc) + 2 + s * 2);
    if (src == 2'b01 && t) r = 32'(tgt) - 32'(tgt % 2);
    return r[15:0];
  endfunction

  // Drives one full fetch+exec of an instruction and reports what was observed
  task automatic do_instr(input int waits, input logic [15:0] word, input logic [1:0] src,
                          input logic h, input logic [2:0] c, input logic [8:0] off,
                          input logic [15:0] tgt, input logic z, v, n,
                          output logic [15:0] a_seen, output logic fetch_ok,
                          output logic [15:0] i_seen, output logic v_seen,
                          output logic [15:0] p2_seen);
    a_seen   = imem.imem_addr;
    fetch_ok = imem.imem_req && !instr_valid && !halted;
    for (int w = 0; w < waits; w++) begin
      imem.imem_ready = 1'b0;
      imem.imem_rdata = 16'($urandom);
      step();
      if (imem.imem_addr !== a_seen || imem.imem_req !== 1'b1 || instr_valid !== 1'b0)
        fetch_ok = 1'b0;
    end
    imem.imem_ready = 1'b1;
    imem.imem_rdata = word;
    step();
    i_seen  = instr_out;
    v_seen  = instr_valid;
    p2_seen = pc_plus2;
    imem.imem_ready = 1'($urandom);
    imem.imem_rdata = 16'($urandom);
    pc_source = src; hlt = h; cond = c; br_offset = off; br_target = tgt;
    flag_z = z; flag_v = v; flag_n = n;
    step();
    hlt = 1'b0;
    pc_source = 2'b00;
    imem.imem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    imem.imem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic jump_to(input logic [15:0] target);
    logic [15:0] a, i, p2;
    logic ok, vv;
    do_instr(0, 16'h0000, 2'b01, 1'b0, 3'b111, 9'h000, target, 1'b0, 1'b0, 1'b0, a, ok, i, vv, p2);
    n_checks++;
    if (imem.imem_addr !== target) begin
      n_fail++;
      $display("FAIL jump_to: addr=%h expected=%h", imem.imem_addr, target);
    end
  endtask

  task automatic test_reset();
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 16'hA5A5;
    rst = 1'b1;
    step();
    n_checks++;
    if ({imem.imem_req, instr_valid, halted} !== 3'b000 || imem.imem_addr !== 16'h0000 ||
        instr_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: req/valid/halt=%b%b%b addr=%h instr=%h expected 000/0000/0000",
               imem.imem_req, instr_valid, halted, imem.imem_addr, instr_out);
    end
    imem.imem_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_after_reset: req=%b expected 1", imem.imem_req);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] a, i, p2, w;
    logic ok, vv;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      w = 16'($urandom);
      do_instr(0, w, 2'b00, 1'b0, 3'($urandom), 9'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), a, ok, i, vv, p2);
      n_checks++;
      if (a !== 16'(2 * k) || i !== w || vv !== 1'b1 || ok !== 1'b1 || p2 !== 16'(2 * k + 2)) begin
        n_fail++;
        $display("FAIL seq_%0d: addr=%h instr=%h valid=%b fetch_ok=%b p2=%h expected addr=%h instr=%h 1 1 p2=%h",
                 k, a, i, vv, ok, p2, 16'(2 * k), w, 16'(2 * k + 2));
      end
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] a, i, p2;
    logic ok, vv;
    apply_reset();
    do_instr(0, 16'h1111, 2'b00, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0, a, ok, i, vv, p2);
    do_instr(0, 16'h2222, 2'b10, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0, a, ok, i, vv, p2);
    do_instr(3, 16'hC0DE, 2'b00, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0, a, ok, i, vv, p2);
    n_checks++;
    if (a !== 16'h0004 || ok !== 1'b1 || vv !== 1'b1 || i !== 16'hC0DE) begin
      n_fail++;
      $display("FAIL wait_states: addr=%h hold_ok=%b valid=%b instr=%h expected 0004 1 1 c0de",
               a, ok, vv, i);
    end
  endtask

  task automatic test_branch_rel();
    logic [15:0] a, i, p2;
    logic ok, vv;
    logic [2:0]  cs [3] = '{3'b001, 3'b001, 3'b111};
    logic [8:0]  os [3] = '{9'h1FE, 9'h1FE, 9'h0FF};
    logic        zs [3] = '{1'b1, 1'b0, 1'b0};
    logic [15:0] es [3] = '{16'h000E, 16'h0012, 16'h0210};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      jump_to(16'h0010);
      do_instr(0, 16'h0, 2'b11, 1'b0, cs[k], os[k], 16'hFFFF, zs[k], 1'b0, 1'b0, a, ok, i, vv, p2);
      n_checks++;
      if (imem.imem_addr !== es[k] || p2 !== 16'h0012) begin
        n_fail++;
        $display("FAIL branch_rel_%0d: addr=%h p2=%h expected addr=%h p2=0012",
                 k, imem.imem_addr, p2, es[k]);
      end
    end
  endtask

  task automatic test_branch_reg();
    logic [15:0] a, i, p2;
    logic ok, vv;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      jump_to(16'h0040);
      do_instr(0, 16'h0, 2'b01, 1'b0, 3'b110, 9'h0, 16'h1235, 1'b0, (k == 0), 1'b0,
               a, ok, i, vv, p2);
      n_checks++;
      if (imem.imem_addr !== ((k == 0) ? 16'h1234 : 16'h0042)) begin
        n_fail++;
        $display("FAIL branch_reg_%0d: addr=%h expected=%h", k, imem.imem_addr,
                 (k == 0) ? 16'h1234 : 16'h0042);
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] a, i, p2;
    logic ok, vv;
    int bad;
    apply_reset();
    jump_to(16'h0020);
    do_instr(0, 16'hF000, 2'b00, 1'b1, 3'd0, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0, a, ok, i, vv, p2);
    n_checks++;
    if (halted !== 1'b1 || imem.imem_req !== 1'b0 || imem.imem_addr !== 16'h0020) begin
      n_fail++;
      $display("FAIL halt_entry: halted=%b req=%b addr=%h expected 1 0 0020",
               halted, imem.imem_req, imem.imem_addr);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      imem.imem_ready = 1'b1;
      imem.imem_rdata = 16'($urandom);
      step();
      if (halted !== 1'b1 || imem.imem_req !== 1'b0 || instr_valid !== 1'b0 ||
          imem.imem_addr !== 16'h0020) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL halt_sticky: %0d bad cycles, expected 0", bad);
    end
    apply_reset();
    n_checks++;
    if (halted !== 1'b0 || imem.imem_addr !== 16'h0000 || imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_release: halted=%b addr=%h req=%b expected 0 0000 1",
               halted, imem.imem_addr, imem.imem_req);
    end
  endtask

  task automatic test_wrap_and_abort();
    logic [15:0] a, i, p2;
    logic ok, vv;
    apply_reset();
    jump_to(16'hFFFE);
    do_instr(0, 16'h0, 2'b00, 1'b0, 3'd0, 9'd0, 16'd0, 1'b0, 1'b0, 1'b0, a, ok, i, vv, p2);
    n_checks++;
    if (imem.imem_addr !== 16'h0000 || p2 !== 16'h0000) begin
      n_fail++;
      $display("FAIL pc_wrap: addr=%h p2=%h expected 0000 0000", imem.imem_addr, p2);
    end
    jump_to(16'h0100);
    imem.imem_ready = 1'b0;
    step();
    rst = 1'b1;
    imem.imem_ready = 1'b1;
    imem.imem_rdata = 16'hBEEF;
    step();
    n_checks++;
    if (instr_valid !== 1'b0 || imem.imem_req !== 1'b0 || instr_out !== 16'h0000 ||
        imem.imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_abort: valid=%b req=%b instr=%h addr=%h expected 0 0 0000 0000",
               instr_valid, imem.imem_req, instr_out, imem.imem_addr);
    end
    imem.imem_ready = 1'b0;
    rst = 1'b0;
    step();
    n_checks++;
    if (instr_valid !== 1'b0 || imem.imem_addr !== 16'h0000 || imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL post_abort: valid=%b addr=%h req=%b expected 0 0000 1",
               instr_valid, imem.imem_addr, imem.imem_req);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, i, p2, w, exp_pc, tgt;
    logic [1:0]  src;
    logic [2:0]  c;
    logic [8:0]  off;
    logic        h, z, v, n, ok, vv;
    apply_reset();
    exp_pc = 16'h0000;
    for (int k = 0; k < 200; k++) begin
      w = 16'($urandom); src = 2'($urandom); c = 3'($urandom); off = 9'($urandom);
      tgt = 16'($urandom); z = 1'($urandom); v = 1'($urandom); n = 1'($urandom);
      h = ($urandom_range(0, 19) == 0);
      do_instr(int'($urandom_range(0, 2)), w, src, h, c, off, tgt, z, v, n, a, ok, i, vv, p2);
      n_checks++;
      if (a !== exp_pc || i !== w || vv !== 1'b1 || ok !== 1'b1 || p2 !== 16'(exp_pc + 16'd2)) begin
        n_fail++;
        $display("FAIL rand_%0d: addr=%h instr=%h valid=%b ok=%b p2=%h expected addr=%h instr=%h",
                 k, a, i, vv, ok, p2, exp_pc, w);
      end
      if (h) begin
        n_checks++;
        if (halted !== 1'b1 || imem.imem_addr !== exp_pc) begin
          n_fail++;
          $display("FAIL rand_halt_%0d: halted=%b addr=%h expected 1 %h",
                   k, halted, imem.imem_addr, exp_pc);
        end
        apply_reset();
        exp_pc = 16'h0000;
      end else begin
        exp_pc = model_next(exp_pc, src, c, off, tgt, z, v, n);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    imem.imem_ready = 1'b0;
    imem.imem_rdata = 16'h0000;
    pc_source = 2'b00; hlt = 1'b0; cond = 3'd0; br_offset = 9'd0; br_target = 16'd0;
    flag_z = 1'b0; flag_v = 1'b0; flag_n = 1'b0;
    test_reset();
    test_sequential();
    test_wait_states();
    test_branch_rel();
    test_branch_reg();
    test_halt();
    test_wrap_and_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
